divider: RTL and testbench

//   Iterative radix-2 restoring divider for the Citrus EX stage; the companion
//   of the combinational multiplier, serving DIV/DIVU. Takes dividend/divisor and
//   the same signed-select flag `symbol`, returns quotient and remainder for HI/LO

---
 rtl/divider_pkg.sv | 19 +
 rtl/divider_step.sv | 29 ++
 rtl/divider.sv | 135 +++++++++++++
 tb/tb_divider.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the iterative restoring divider: FSM encoding and
// the step-counter width helper.
package divider_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 32;

    // One counter value per restoring step, so log2 of the operand width.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/divider_step.sv
// One radix-2 restoring step: shift {rem,quo} left by one, trial-subtract the
// divisor magnitude, keep the difference and set the quotient bit if no borrow.
module divider_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < dvsr always holds, so the extra bit only ever carries the borrow.
    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        diff    = shifted - {1'b0, dvsr};
        if (diff[WIDTH]) begin
            rem_out = shifted[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end else begin
            rem_out = diff[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/divider.sv
// Iterative signed/unsigned restoring divider for DIV/DIVU: magnitudes are
// divided over WIDTH cycles, then signs are applied in a single fix-up cycle.
//
//   state  | meaning
//   IDLE   | waiting for start; operands and signs captured on accept
//   CALC   | one restoring step per clock, WIDTH steps in total
//   FIX    | apply quotient/remainder signs, load q/r
//   DONE   | done pulse for one cycle, then back to IDLE
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             symbol,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_zero
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    div_state_t     state, state_n;
    logic [CW-1:0]  cnt;
    logic [WIDTH-1:0] rem, quo, dvsr;
    logic [WIDTH-1:0] rem_step, quo_step;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             neg_q, neg_r;
    logic             b_is_zero;

    // The most negative value negates to itself, which is exactly its
    // magnitude when read as unsigned.
    assign a_mag     = (symbol && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (symbol && b[WIDTH-1]) ? -b : b;
    assign b_is_zero = (b == '0);

    divider_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .dvsr    (dvsr),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (start && !cancel) begin
                    state_n = b_is_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (cancel) begin
                    state_n = S_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_n = S_FIX;
                end
            end
            S_FIX:   state_n = cancel ? S_IDLE : S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            q        <= '0;
            r        <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !cancel) begin
                        if (b_is_zero) begin
                            q        <= '1;
                            r        <= a;
                            div_zero <= 1'b1;
                        end else begin
                            rem   <= '0;
                            quo   <= a_mag;
                            dvsr  <= b_mag;
                            neg_q <= symbol & (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r <= symbol & a[WIDTH-1];
                            cnt   <= '0;
                        end
                    end
                end
                S_CALC: begin
                    if (!cancel) begin
                        rem <= rem_step;
                        quo <= quo_step;
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    if (!cancel) begin
                        q        <= neg_q ? -quo : quo;
                        r        <= neg_r ? -rem : rem;
                        div_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    // A flush landing on the DONE cycle must not let the pipeline consume it.
    assign done = (state == S_DONE) && !cancel;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: a latency/result model built on plain
// integer division is compared against busy/done/q/r/div_zero every cycle.
module tb_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         symbol = 1'b0;
    logic         cancel = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] q, r;

    divider #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .symbol   (symbol),
        .cancel   (cancel),
        .busy     (busy),
        .done     (done),
        .q        (q),
        .r        (r),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_div(input logic [W-1:0] x, input logic [W-1:0] y, input logic sg,
                                    output logic [W-1:0] qq, output logic [W-1:0] rr, output logic dz);
        longint sx, sy;
        if (y == '0) begin
            qq = '1;
            rr = x;
            dz = 1'b1;
        end else if (sg) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            qq = W'(sx / sy);
            rr = W'(sx % sy);
            dz = 1'b0;
        end else begin
            qq = x / y;
            rr = x % y;
            dz = 1'b0;
        end
    endfunction

    // Model: left = edges until done is visible (-1 = idle, 0 = done cycle).
    int           left = -1;
    logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    logic         m_dz = 1'b0, p_dz = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            left = -1;
            m_q  = '0;
            m_r  = '0;
            m_dz = 1'b0;
        end else if (left == -1) begin
            if (start && !cancel) begin
                ref_div(a, b, symbol, p_q, p_r, p_dz);
                if (p_dz) begin
                    left = 0;
                    m_q  = p_q;
                    m_r  = p_r;
                    m_dz = 1'b1;
                end else begin
                    left = W + 1;
                end
            end
        end else if (cancel || left == 0) begin
            left = -1;
        end else begin
            left--;
            if (left == 0) begin
                m_q  = p_q;
                m_r  = p_r;
                m_dz = p_dz;
            end
        end
    end

    bit mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", busy, (left != -1));
            chk("done", done, (left == 0));
            chk("q", q, m_q);
            chk("r", r, m_r);
            chk("div_zero", div_zero, m_dz);
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sg, input bit lit,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        int n;
        @(negedge clk);
        a = x; b = y; symbol = sg; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; symbol = ~sg;
        wait_done(n);
        chk("latency", n, (y == '0) ? 0 : W + 1);
        if (lit) begin
            chk("lit_q", q, eq);
            chk("lit_r", r, er);
            chk("lit_div_zero", div_zero, edz);
        end
        @(negedge clk);
        chk("done_single_cycle", done, 1'b0);
        chk("busy_after_done", busy, 1'b0);
    endtask

    initial begin
        int n;
        logic [W-1:0] held_q, held_r, x, y;
        logic sg;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        chk("reset_q", q, '0);
        chk("reset_busy", busy, 1'b0);
        rst_n = 1'b1;

        run_op(32'hFA4B7D9F, 32'h4D6C4E3A, 1'b0, 1, 32'h00000003, 32'h120692F1, 1'b0);
        run_op(32'hFA4B7D9F, 32'h4D6C4E3A, 1'b1, 1, 32'h00000000, 32'hFA4B7D9F, 1'b0);
        run_op(32'hFFFFFFF9, 32'h00000002, 1'b1, 1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        run_op(32'hFFFFFFF9, 32'h00000002, 1'b0, 1, 32'h7FFFFFFC, 32'h00000001, 1'b0);
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 1, 32'h80000000, 32'h00000000, 1'b0);
        run_op(32'h00001234, 32'h00000000, 1'b0, 1, 32'hFFFFFFFF, 32'h00001234, 1'b1);
        run_op(32'h80000000, 32'h00000003, 1'b1, 1, 32'hD5555556, 32'hFFFFFFFE, 1'b0);

        // Second start while busy must be dropped.
        @(negedge clk);
        a = 32'd100; b = 32'd7; symbol = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        a = 32'd5; b = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("ignored_start_latency", n + 5, W + 1);
        chk("ignored_start_q", q, 32'd14);
        chk("ignored_start_r", r, 32'd2);
        @(negedge clk);

        // Cancel beats start in IDLE.
        held_q = q;
        @(negedge clk);
        a = 32'd9; b = 32'd3; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("cancel_over_start_busy", busy, 1'b0);

        // Cancel at the tenth edge after accept.
        held_q = q;
        held_r = r;
        @(negedge clk);
        a = 32'd1000; b = 32'd10; symbol = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", busy, 1'b0);
        repeat (40) @(negedge clk);
        chk("cancel_q_held", q, held_q);
        chk("cancel_r_held", r, held_r);

        // Reset in the middle of CALC.
        @(negedge clk);
        a = 32'd77; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset_q", q, '0);
        chk("midreset_r", r, '0);
        chk("midreset_busy", busy, 1'b0);
        run_op(32'd77, 32'd5, 1'b0, 1, 32'd15, 32'd2, 1'b0);

        for (int i = 0; i < 40; i++) begin
            x  = $urandom;
            y  = $urandom;
            sg = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: y = '0;
                1: y = '1;
                2: x = 32'h80000000;
                3: y = W'($urandom_range(1, 15));
                default: ;
            endcase
            if (y != '0 && $urandom_range(0, 5) == 0) begin
                @(negedge clk);
                a = x; b = y; symbol = sg; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat ($urandom_range(0, W - 1)) @(negedge clk);
                cancel = 1'b1;
                @(negedge clk);
                cancel = 1'b0;
                chk("rand_cancel_busy", busy, 1'b0);
            end else begin
                run_op(x, y, sg, 0, '0, '0, 1'b0);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
